tea_decrypt_seq: RTL and testbench



---
 rtl/tea_pkg.sv | 46 ++++
 rtl/tea_round_dec.sv | 22 ++
 rtl/tea_decrypt_seq.sv | 149 ++++++++++++++
 tb/tb_tea_decrypt_seq.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tea_pkg.sv
// Shared TEA definitions for the iterative decryptor.
//
// Contents:
//   DELTA                       TEA key-schedule constant
//   DECRYPT_SUM_0               starting sum for a 32-round decrypt (DELTA*32 mod 2^32)
//   PDF_PLAIN_HEADER_1/2        "%PDF-1.6" split into v0/v1 words
//   PDF_ENCRYPTED_HEADER_1/2    that header encrypted under KEY
//   KEY                         reference 128-bit key
//   tea_state_t                 decryptor FSM states
//   tea_dec_round()             one decrypt round, returns the updated {v0,v1}
package tea_pkg;

    localparam logic [31:0]  DELTA                  = 32'h9e37_79b9;
    localparam logic [31:0]  DECRYPT_SUM_0          = 32'hc6ef_3720;
    localparam logic [31:0]  PDF_PLAIN_HEADER_1     = 32'h2550_4446;
    localparam logic [31:0]  PDF_PLAIN_HEADER_2     = 32'h2d31_2e36;
    localparam logic [31:0]  PDF_ENCRYPTED_HEADER_1 = 32'h42c3_7893;
    localparam logic [31:0]  PDF_ENCRYPTED_HEADER_2 = 32'hfbc2_d912;
    localparam logic [127:0] KEY = 128'h4875_6c6b_2069_7320_7468_616c_616d_6963;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } tea_state_t;

    // v1 is updated first and the new v1 feeds the v0 update, undoing the
    // encrypt round in reverse order. All arithmetic wraps mod 2^32.
    function automatic logic [63:0] tea_dec_round(
        input logic [31:0]  v0,
        input logic [31:0]  v1,
        input logic [127:0] key,
        input logic [31:0]  sum
    );
        logic [31:0] k0, k1, k2, k3;
        logic [31:0] nv0, nv1;
        k0  = key[127:96];
        k1  = key[95:64];
        k2  = key[63:32];
        k3  = key[31:0];
        nv1 = v1 - (((v0 << 4) + k2) ^ (v0 + sum) ^ ((v0 >> 5) + k3));
        nv0 = v0 - (((nv1 << 4) + k0) ^ (nv1 + sum) ^ ((nv1 >> 5) + k1));
        return {nv0, nv1};
    endfunction

endpackage

// File: rtl/tea_round_dec.sv
// Combinational single TEA decrypt round.
//
// Ports:
//   v0, v1     in   current block words
//   key        in   128-bit key {k0,k1,k2,k3}
//   sum        in   round sum for this round
//   v0_next    out  v0 after the round
//   v1_next    out  v1 after the round
module tea_round_dec
    import tea_pkg::*;
(
    input  logic [31:0]  v0,
    input  logic [31:0]  v1,
    input  logic [127:0] key,
    input  logic [31:0]  sum,
    output logic [31:0]  v0_next,
    output logic [31:0]  v1_next
);

    assign {v0_next, v1_next} = tea_dec_round(v0, v1, key, sum);

endmodule

// File: rtl/tea_decrypt_seq.sv
// Iterative TEA decryptor: one round per enabled clock over a valid/ready
// stream of 64-bit blocks, with a sticky check that the first block of each
// file decrypts to the expected plaintext header.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   ena                 clock enable; low freezes everything and blocks handshakes
//   start_frame         with an input handshake, marks the first block of a file
//   in_valid/in_ready   input handshake
//   in_block            ciphertext {v0,v1}
//   key                 {k0,k1,k2,k3}, sampled at accept
//   out_valid/out_ready output handshake
//   out_block           plaintext {v0,v1}
//   hdr_checked         sticky: first block of the current file has been decrypted
//   hdr_ok              sticky: that block matched HDR_PLAIN
module tea_decrypt_seq #(
    parameter int          ROUNDS       = 32,
    parameter logic [31:0] DELTA        = tea_pkg::DELTA,
    parameter logic [63:0] HDR_PLAIN    = {tea_pkg::PDF_PLAIN_HEADER_1,
                                           tea_pkg::PDF_PLAIN_HEADER_2},
    parameter bit          CHECK_HEADER = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic         start_frame,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [63:0]  in_block,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [63:0]  out_block,
    output logic         hdr_checked,
    output logic         hdr_ok
);

    import tea_pkg::*;

    // One extra counter bit so the count can reach ROUNDS without wrapping.
    localparam int          CW       = $clog2(ROUNDS + 1);
    localparam logic [31:0] SUM_INIT = DELTA * 32'(ROUNDS);
    localparam logic [CW-1:0] LAST   = CW'(ROUNDS - 1);

    tea_state_t     state, state_next;
    logic [31:0]    v0, v1, sum;
    logic [127:0]   key_q;
    logic [CW-1:0]  count;
    logic           first;
    logic [31:0]    v0_next, v1_next;
    logic           last_round;

    tea_round_dec u_round (
        .v0      (v0),
        .v1      (v1),
        .key     (key_q),
        .sum     (sum),
        .v0_next (v0_next),
        .v1_next (v1_next)
    );

    // count holds the index of the round being executed this cycle.
    assign last_round = (count == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // in_ready is gated by rst so it stays low for the whole reset pulse.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                in_ready = ena & ~rst;
                if (ena && in_valid) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (ena && last_round) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (ena && out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Datapath: load at accept, one round per enabled RUN cycle, capture the
    // result and evaluate the header on the last round. hdr_* are cleared by a
    // start_frame accept so a stale verdict never outlives its file.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v0          <= '0;
            v1          <= '0;
            sum         <= '0;
            key_q       <= '0;
            count       <= '0;
            first       <= 1'b0;
            out_block   <= '0;
            hdr_checked <= 1'b0;
            hdr_ok      <= 1'b0;
        end else if (ena) begin
            unique case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        v0    <= in_block[63:32];
                        v1    <= in_block[31:0];
                        key_q <= key;
                        first <= start_frame;
                        sum   <= SUM_INIT;
                        count <= '0;
                        if (start_frame) begin
                            hdr_checked <= 1'b0;
                            hdr_ok      <= 1'b0;
                        end
                    end
                end
                ST_RUN: begin
                    v0    <= v0_next;
                    v1    <= v1_next;
                    sum   <= sum - DELTA;
                    count <= count + 1'b1;
                    if (last_round) begin
                        out_block <= {v0_next, v1_next};
                        if (first && CHECK_HEADER) begin
                            hdr_checked <= 1'b1;
                            hdr_ok      <= ({v0_next, v1_next} == HDR_PLAIN);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tea_decrypt_seq.sv
// Self-checking bench for tea_decrypt_seq: scoreboard of expected plaintexts
// filled at accept and drained as blocks leave the core.
module tb_tea_decrypt_seq;

    localparam logic [31:0]  TB_DELTA = 32'h9e37_79b9;
    localparam logic [63:0]  HDR      = 64'h2550_4446_2d31_2e36;
    localparam logic [127:0] KEY0     = 128'h0;
    localparam logic [63:0]  CT1      = 64'h41ea3a0a_94baa940;
    localparam logic [127:0] KEY2     = 128'h4875_6c6b_2069_7320_7468_616c_616d_6963;
    localparam logic [63:0]  CT2      = 64'h42c37893_fbc2d912;

    typedef struct packed {
        logic [63:0] blk;
        logic        first;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         ena;
    logic         start_frame;
    logic         in_valid;
    logic         in_ready;
    logic [63:0]  in_block;
    logic [127:0] key;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  out_block;
    logic         hdr_checked;
    logic         hdr_ok;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];
    logic exp_checked = 1'b0;
    logic exp_ok      = 1'b0;

    tea_decrypt_seq dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .start_frame (start_frame),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_block    (in_block),
        .key         (key),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_block   (out_block),
        .hdr_checked (hdr_checked),
        .hdr_ok      (hdr_ok)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference TEA decryption, straight from the textbook algorithm.
    function automatic logic [63:0] tb_tea_dec(input logic [63:0] ct, input logic [127:0] k);
        logic [31:0] y, z, s;
        y = ct[63:32];
        z = ct[31:0];
        s = TB_DELTA << 5;
        for (int r = 0; r < 32; r++) begin
            z -= ((y << 4) + k[63:32]) ^ (y + s) ^ ((y >> 5) + k[31:0]);
            y -= ((z << 4) + k[127:96]) ^ (z + s) ^ ((z >> 5) + k[95:64]);
            s -= TB_DELTA;
        end
        return {y, z};
    endfunction

    // Removes the oldest expected block and updates the expected header flags.
    function automatic logic [63:0] pop_expected();
        exp_t e;
        if (exp_q.size() == 0) return 64'hdead_beef_dead_beef;
        e = exp_q.pop_front();
        if (e.first) begin
            exp_checked = 1'b1;
            exp_ok      = (e.blk == HDR);
        end
        return e.blk;
    endfunction

    // Offers one block and waits (bounded) for the core to accept it.
    task automatic send_block(input logic [63:0] blk, input logic [127:0] k, input logic sf);
        int n;
        in_block    = blk;
        key         = k;
        start_frame = sf;
        in_valid    = 1'b1;
        n = 0;
        while (in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL accept_timeout: in_ready=%b required 1", in_ready);
            in_valid    = 1'b0;
            start_frame = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid    = 1'b0;
        start_frame = 1'b0;
        key         = {$urandom, $urandom, $urandom, $urandom};
        exp_q.push_back('{blk: tb_tea_dec(blk, k), first: sf});
        if (sf) begin
            exp_checked = 1'b0;
            exp_ok      = 1'b0;
        end
        n_checks++;
        if (hdr_checked !== exp_checked || hdr_ok !== exp_ok) begin
            n_fail++;
            $display("[TB] FAIL hdr_after_accept: got %b/%b required %b/%b",
                     hdr_checked, hdr_ok, exp_checked, exp_ok);
        end
    endtask

    // Waits (bounded) for a result, compares it and completes the handshake.
    task automatic recv_block(input int max_wait, input int exp_lat);
        int n;
        logic [63:0] exp_blk;
        out_ready = 1'b1;
        n = 0;
        while (out_valid !== 1'b1 && n < max_wait) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL output_timeout: out_valid=%b required 1", out_valid);
            out_ready = 1'b0;
            return;
        end
        if (exp_lat > 0) begin
            n_checks++;
            if (n != exp_lat) begin
                n_fail++;
                $display("[TB] FAIL latency: got %0d required %0d", n, exp_lat);
            end
        end
        exp_blk = pop_expected();
        n_checks++;
        if (out_block !== exp_blk) begin
            n_fail++;
            $display("[TB] FAIL out_block: got %h required %h", out_block, exp_blk);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL out_valid_after_handshake: got %b required 0", out_valid);
        end
        n_checks++;
        if (hdr_checked !== exp_checked || hdr_ok !== exp_ok) begin
            n_fail++;
            $display("[TB] FAIL hdr_after_output: got %b/%b required %b/%b",
                     hdr_checked, hdr_ok, exp_checked, exp_ok);
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #2;
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_block !== 64'h0 ||
            hdr_checked !== 1'b0 || hdr_ok !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_values: rdy=%b vld=%b blk=%h chk=%b ok=%b required 0/0/0/0/0",
                     in_ready, out_valid, out_block, hdr_checked, hdr_ok);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL idle_in_ready: got %b required 1", in_ready);
        end
    endtask

    // All-zero key; the plaintext is zero and therefore not the header.
    task automatic test_vector_zero_key();
        send_block(CT1, KEY0, 1'b1);
        recv_block(100, 33);
        n_checks++;
        if (hdr_checked !== 1'b1 || hdr_ok !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL vec1_hdr: got %b/%b required 1/0", hdr_checked, hdr_ok);
        end
    endtask

    task automatic test_vector_pdf_header();
        send_block(CT2, KEY2, 1'b1);
        recv_block(100, 33);
    endtask

    // A non-first block keeps the verdict, a stray start_frame does nothing,
    // and a new first block that mismatches clears hdr_ok.
    task automatic test_header_sticky();
        start_frame = 1'b1;
        repeat (2) @(posedge clk);
        #1 start_frame = 1'b0;
        n_checks++;
        if (hdr_checked !== exp_checked || hdr_ok !== exp_ok) begin
            n_fail++;
            $display("[TB] FAIL stray_start_frame: got %b/%b required %b/%b",
                     hdr_checked, hdr_ok, exp_checked, exp_ok);
        end
        send_block(CT1, KEY0, 1'b0);
        recv_block(100, 0);
        send_block(CT1, KEY0, 1'b1);
        recv_block(100, 0);
    endtask

    // Result held 10 cycles with a second block waiting at the input.
    task automatic test_back_to_back();
        int n;
        logic [63:0] exp_a;
        logic stable_bad;
        send_block(CT1, KEY0, 1'b1);
        out_ready = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        in_block    = CT2;
        key         = KEY2;
        start_frame = 1'b0;
        in_valid    = 1'b1;
        exp_a       = pop_expected();
        stable_bad  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || out_block !== exp_a || in_ready !== 1'b0)
                stable_bad = 1'b1;
        end
        n_checks++;
        if (stable_bad !== 1'b0 || out_block !== exp_a) begin
            n_fail++;
            $display("[TB] FAIL hold_in_done: blk=%h vld=%b rdy=%b required %h/1/0",
                     out_block, out_valid, in_ready, exp_a);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reload_after_handshake: rdy=%b vld=%b required 1/0",
                     in_ready, out_valid);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        key      = 128'h0123_4567_89ab_cdef_0123_4567_89ab_cdef;
        exp_q.push_back('{blk: tb_tea_dec(CT2, KEY2), first: 1'b0});
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL second_accept: in_ready=%b required 0", in_ready);
        end
        recv_block(100, 33);
    endtask

    // ena alternates during RUN; 32 enabled edges span 64 clocks.
    task automatic test_ena_toggle();
        logic early;
        send_block(CT1, KEY0, 1'b0);
        early = 1'b0;
        for (int i = 1; i <= 64; i++) begin
            ena = (i % 2 == 0);
            @(posedge clk);
            #1;
            if (i < 64 && out_valid !== 1'b0) early = 1'b1;
        end
        n_checks++;
        if (early !== 1'b0 || out_valid !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL ena_timing: early=%b vld=%b required 0/1", early, out_valid);
        end
        ena       = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL ena_blocks_handshake: out_valid=%b required 1", out_valid);
        end
        ena = 1'b1;
        recv_block(5, 0);
        ena = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL ena_low_in_ready: got %b required 0", in_ready);
        end
        ena = 1'b1;
        #1;
    endtask

    // Reset during RUN aborts the block; a new block then runs normally.
    task automatic test_reset_mid_run();
        send_block(CT1, KEY0, 1'b0);
        repeat (15) @(posedge clk);
        #2;
        n_checks++;
        if (hdr_checked !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL pre_reset_hdr: got %b required 1", hdr_checked);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_block !== 64'h0 ||
            hdr_checked !== 1'b0 || hdr_ok !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL async_reset: rdy=%b vld=%b blk=%h chk=%b ok=%b required 0/0/0/0/0",
                     in_ready, out_valid, out_block, hdr_checked, hdr_ok);
        end
        exp_q.delete();
        exp_checked = 1'b0;
        exp_ok      = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL aborted_block_output: out_valid=%b required 0", out_valid);
        end
        send_block(CT2, KEY2, 1'b1);
        recv_block(100, 33);
    endtask

    initial begin
        rst         = 1'b0;
        ena         = 1'b1;
        start_frame = 1'b0;
        in_valid    = 1'b0;
        in_block    = '0;
        key         = '0;
        out_ready   = 1'b0;

        test_reset();
        test_vector_zero_key();
        test_vector_pdf_header();
        test_header_sticky();
        test_back_to_back();
        test_ena_toggle();
        test_reset_mid_run();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
